cmd_stream_encoder: RTL and testbench
=====================================

Name: cmd_stream_encoder

Overview:
- Host-side encoder for the uTPU UART instruction protocol: the transmit end of the byte stream that the top-level controller fetches from its RX FIFO and decodes.
- Accepts field-level commands, packs them into 16-bit instruction words plus an optional 16-bit STORE address word, and serialises them as bytes, low byte first.
- Output is a valid/ready byte stream to a UART TX or TX FIFO.
- Used in loopback and system benches, and as the FPGA-side command source.

Parameters:
- FIFO_DATA_WIDTH, 8, width of one stream byte.
- BUFFER_WORD_SIZE, 16, instruction word width.
- BUFFER_SIZE, 512, unified buffer depth.
- ADDRESS_SIZE, $clog2(BUFFER_SIZE), address field width.
- OPCODE_WIDTH, 3, opcode field width.
- CMD_DEPTH, 4, command queue depth (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_opcode  in  OPCODE_WIDTH  STORE=0 FETCH=1 RUN=2 LOAD=3 HALT=4 NOP=5
- cmd_flags  in  3  packed into word[5:3]
- cmd_address  in  ADDRESS_SIZE  packed into word[15:16-ADDRESS_SIZE]
- cmd_store_addr  in  ADDRESS_SIZE  trailing address word for STORE with flags[1]=1
- byte_valid  out  1  byte_data valid
- byte_ready  in  1  sink accepts byte
- byte_data  out  FIFO_DATA_WIDTH  stream byte
- busy  out  1  queue non-empty or byte in flight
- halted  out  1  HALT fully transmitted
- err_illegal  out  1  one-cycle pulse when opcode 6/7 is accepted
- cmd_count  out  16  commands fully transmitted, wraps at 0xFFFF

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
- Outputs after reset: cmd_ready=1, byte_valid=0, byte_data=0, busy=0, halted=0, err_illegal=0, cmd_count=0. Queue flushed.
- Reset mid-command drops any partial byte sequence immediately; byte_valid=0 the next cycle.
- Instruction word packing:
  - word[2:0]=opcode; word[5:3]=flags; word[6]=0; word[15:7]=address.
  - HALT and NOP force flags and address to 0.
- Address word: zero-extended cmd_store_addr, low byte first. Sent only when opcode=STORE and flags[1]=1; the command is then 4 bytes, otherwise 2.
- Acceptance:
  - cmd_ready = !queue_full && !halt_accepted.
  - Illegal opcodes (6, 7) are accepted but not queued; err_illegal pulses the following cycle.
  - Once HALT is accepted, cmd_ready=0 from the next cycle until reset.
- Storage: a staging register holds the command being sent, plus a CMD_DEPTH queue behind it. With byte_ready held 0, CMD_DEPTH+1 commands are accepted before cmd_ready falls.
- FSM states:
  - IDLE: queue empty -> stay. Otherwise pop -> LO; byte_valid is asserted the cycle after the pop.
  - LO: on handshake -> HI.
  - HI: on handshake -> ALO if an address word is needed; else command done.
  - ALO: on handshake -> AHI.
  - AHI: on handshake -> command done.
  - Command done: go to HALTED if opcode=HALT. Otherwise pop the next command directly into LO (no bubble); if the queue is empty, go to IDLE.
  - HALTED: terminal until reset; halted=1, byte_valid=0.
- Handshake rules:
  - Transfer occurs on byte_valid && byte_ready.
  - byte_data and byte_valid are held stable while byte_valid && !byte_ready.
  - Throughput is 1 byte/cycle while byte_ready=1.
  - byte_valid never depends combinationally on byte_ready.
- Completion timing: cmd_count increments and halted sets in the cycle after the last byte's handshake.
- Simultaneous push and pop with the queue full: the push is blocked because cmd_ready is derived from full only, with no pass-through.
- Latency from cmd accept to first byte_valid: 2 cycles when idle (queue write, then pop/stage).

Decomposition:
- Shared package tpu_isa_pkg holds:
  - opcode_e (STORE..NOP);
  - field offsets OPC_LSB=0, FLAGS_LSB=3, ADDR_LSB=BUFFER_WORD_SIZE-ADDRESS_SIZE;
  - flag constants FLAG_BOT_MEM=0, FLAG_STORE_ADDR=1, FLAG_COMPUTE=0, FLAG_QUANT=1, FLAG_RELU=2.
- The top-level controller decoder imports the same package.
- One sub-module, cmd_queue: a synchronous FIFO of {need_addr, word, addr_word}, 33 bits wide, with full/empty flags.

Test Plan:
- FETCH, flags=001, address=0x0A5, byte_ready=1 -> bytes 0x89, 0x52; cmd_count=1.
- STORE, flags=010, address=0, store_addr=0x1FF -> bytes 0x10, 0x00, 0xFF, 0x01 back-to-back; cmd_count=1.
- RUN (flags=111, addr=0x003), then HALT (flags=111, addr=0x1FF) -> bytes 0xBA, 0x01, 0x04, 0x00 with no bubble. Then halted=1, cmd_ready=0, and further cmd_valid is ignored.
- Opcode 6 -> err_illegal pulses for 1 cycle, no bytes, cmd_count unchanged. A following NOP -> bytes 0x05, 0x00.
- byte_ready=0 while offering 7 LOADs -> exactly 5 accepted, then cmd_ready=0. byte_data is stable at the first low byte; releasing byte_ready yields 10 bytes in order.
- rst asserted after the first byte of a STORE-with-address -> byte_valid=0 and queue empty. Post-reset, FETCH addr=0 -> 0x01, 0x00.

Source files
------------

// File: rtl/tpu_isa_pkg.sv
// Shared uTPU instruction-set definitions: opcodes, instruction field
// offsets, flag bit positions and the encoder byte-sequencer states.
package tpu_isa_pkg;

   localparam int ISA_WORD_W = 16;
   localparam int ISA_ADDR_W = 9;

   // Instruction word field offsets
   localparam int OPC_LSB   = 0;
   localparam int FLAGS_LSB = 3;
   localparam int ADDR_LSB  = ISA_WORD_W - ISA_ADDR_W;

   // Flag bit positions (STORE)
   localparam int FLAG_BOT_MEM    = 0;
   localparam int FLAG_STORE_ADDR = 1;
   // Flag bit positions (RUN)
   localparam int FLAG_COMPUTE    = 0;
   localparam int FLAG_QUANT      = 1;
   localparam int FLAG_RELU       = 2;

   typedef enum logic [2:0] {
      OP_STORE = 3'd0,
      OP_FETCH = 3'd1,
      OP_RUN   = 3'd2,
      OP_LOAD  = 3'd3,
      OP_HALT  = 3'd4,
      OP_NOP   = 3'd5
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LO     = 3'd1,
      ST_HI     = 3'd2,
      ST_ALO    = 3'd3,
      ST_AHI    = 3'd4,
      ST_HALTED = 3'd5
   } enc_state_e;

endpackage

// File: rtl/cmd_queue.sv
// Synchronous show-ahead FIFO holding packed commands
// {need_addr, instruction word, address word} waiting behind the staging register.
module cmd_queue #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == {CNT_W{1'b0}});
   assign dout  = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy; overflow/underflow are ignored
   always_comb begin
      do_push_s = push && !full;
      do_pop_s  = pop && !empty;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
         default: count_d = count_q;
      endcase
   end

   // Queue state registers, flushed by synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/cmd_stream_encoder.sv
// Host-side uTPU command encoder: packs field-level commands into 16-bit
// instruction words (plus an optional STORE address word) and streams them
// out low byte first over a valid/ready byte interface.
module cmd_stream_encoder
   import tpu_isa_pkg::*;
#(
   parameter int FIFO_DATA_WIDTH  = 8,
   parameter int BUFFER_WORD_SIZE = 16,
   parameter int BUFFER_SIZE      = 512,
   parameter int ADDRESS_SIZE     = $clog2(BUFFER_SIZE),
   parameter int OPCODE_WIDTH     = 3,
   parameter int CMD_DEPTH        = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [OPCODE_WIDTH-1:0]    cmd_opcode,
   input  logic [2:0]                 cmd_flags,
   input  logic [ADDRESS_SIZE-1:0]    cmd_address,
   input  logic [ADDRESS_SIZE-1:0]    cmd_store_addr,
   output logic                       byte_valid,
   input  logic                       byte_ready,
   output logic [FIFO_DATA_WIDTH-1:0] byte_data,
   output logic                       busy,
   output logic                       halted,
   output logic                       err_illegal,
   output logic [15:0]                cmd_count
);

   localparam int ENTRY_W  = 2 * BUFFER_WORD_SIZE + 1;
   localparam int ADDR_POS = BUFFER_WORD_SIZE - ADDRESS_SIZE;

   // Command acceptance / packing
   logic                        accept_s;
   logic                        illegal_s;
   logic                        zero_fields_s;
   logic                        need_addr_s;
   logic                        push_s;
   logic [BUFFER_WORD_SIZE-1:0] word_s;
   logic [BUFFER_WORD_SIZE-1:0] addr_word_s;
   logic                        halt_acc_q, halt_acc_d;
   logic                        err_illegal_q, err_illegal_d;

   // Queue interface
   logic [ENTRY_W-1:0] q_dout_s;
   logic               q_full_s;
   logic               q_empty_s;
   logic               pop_s;

   // Byte sequencer
   enc_state_e                  state_q, state_d;
   logic [ENTRY_W-1:0]          stage_q, stage_d;
   logic                        byte_valid_q, byte_valid_d;
   logic [FIFO_DATA_WIDTH-1:0]  byte_data_q, byte_data_d;
   logic [15:0]                 cmd_count_q, cmd_count_d;
   logic                        halted_q, halted_d;
   logic                        hs_s;
   logic                        done_s;
   logic                        stage_need_s;
   logic [BUFFER_WORD_SIZE-1:0] stage_word_s;
   logic [BUFFER_WORD_SIZE-1:0] stage_aw_s;
   logic [BUFFER_WORD_SIZE-1:0] next_word_s;

   assign cmd_ready   = !q_full_s && !halt_acc_q;
   assign accept_s    = cmd_valid && cmd_ready;
   assign push_s      = accept_s && !illegal_s;

   assign byte_valid  = byte_valid_q;
   assign byte_data   = byte_data_q;
   assign halted      = halted_q;
   assign err_illegal = err_illegal_q;
   assign cmd_count   = cmd_count_q;
   assign busy        = !q_empty_s || (state_q == ST_LO) || (state_q == ST_HI) ||
                        (state_q == ST_ALO) || (state_q == ST_AHI);

   assign stage_need_s = stage_q[ENTRY_W-1];
   assign stage_word_s = stage_q[ENTRY_W-2 -: BUFFER_WORD_SIZE];
   assign stage_aw_s   = stage_q[BUFFER_WORD_SIZE-1:0];
   assign next_word_s  = q_dout_s[ENTRY_W-2 -: BUFFER_WORD_SIZE];

   // Pack the offered command into instruction and address words
   always_comb begin
      illegal_s     = (cmd_opcode > OPCODE_WIDTH'(OP_NOP));
      zero_fields_s = (cmd_opcode == OPCODE_WIDTH'(OP_HALT)) ||
                      (cmd_opcode == OPCODE_WIDTH'(OP_NOP));
      word_s        = '0;
      word_s[OPC_LSB +: OPCODE_WIDTH] = cmd_opcode;
      if (zero_fields_s) begin
         word_s[FLAGS_LSB +: 3]           = 3'b000;
         word_s[ADDR_POS +: ADDRESS_SIZE] = '0;
      end else begin
         word_s[FLAGS_LSB +: 3]           = cmd_flags;
         word_s[ADDR_POS +: ADDRESS_SIZE] = cmd_address;
      end
      need_addr_s = (cmd_opcode == OPCODE_WIDTH'(OP_STORE)) && cmd_flags[FLAG_STORE_ADDR];
      addr_word_s = '0;
      addr_word_s[ADDRESS_SIZE-1:0] = cmd_store_addr;
   end

   // HALT latch closes the command port; illegal opcodes raise a one-cycle flag
   always_comb begin
      err_illegal_d = accept_s && illegal_s;
      if (accept_s && (cmd_opcode == OPCODE_WIDTH'(OP_HALT))) begin
         halt_acc_d = 1'b1;
      end else begin
         halt_acc_d = halt_acc_q;
      end
   end

   cmd_queue #(
      .WIDTH (ENTRY_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .din   ({need_addr_s, word_s, addr_word_s}),
      .pop   (pop_s),
      .dout  (q_dout_s),
      .full  (q_full_s),
      .empty (q_empty_s)
   );

   // Byte sequencer: next state, staged command, registered byte outputs and completion
   always_comb begin
      state_d      = state_q;
      stage_d      = stage_q;
      byte_valid_d = byte_valid_q;
      byte_data_d  = byte_data_q;
      cmd_count_d  = cmd_count_q;
      halted_d     = halted_q;
      pop_s        = 1'b0;
      done_s       = 1'b0;
      hs_s         = byte_valid_q && byte_ready;

      case (state_q)
         ST_IDLE: begin
            if (!q_empty_s) begin
               pop_s        = 1'b1;
               stage_d      = q_dout_s;
               state_d      = ST_LO;
               byte_valid_d = 1'b1;
               byte_data_d  = next_word_s[FIFO_DATA_WIDTH-1:0];
            end else begin
               byte_valid_d = 1'b0;
               byte_data_d  = '0;
            end
         end
         ST_LO: begin
            if (hs_s) begin
               state_d     = ST_HI;
               byte_data_d = stage_word_s[BUFFER_WORD_SIZE-1 -: FIFO_DATA_WIDTH];
            end else begin
               state_d = ST_LO;
            end
         end
         ST_HI: begin
            if (hs_s && stage_need_s) begin
               state_d     = ST_ALO;
               byte_data_d = stage_aw_s[FIFO_DATA_WIDTH-1:0];
            end else if (hs_s) begin
               done_s = 1'b1;
            end else begin
               state_d = ST_HI;
            end
         end
         ST_ALO: begin
            if (hs_s) begin
               state_d     = ST_AHI;
               byte_data_d = stage_aw_s[BUFFER_WORD_SIZE-1 -: FIFO_DATA_WIDTH];
            end else begin
               state_d = ST_ALO;
            end
         end
         ST_AHI: begin
            if (hs_s) begin
               done_s = 1'b1;
            end else begin
               state_d = ST_AHI;
            end
         end
         ST_HALTED: begin
            byte_valid_d = 1'b0;
            byte_data_d  = '0;
            halted_d     = 1'b1;
         end
         default: begin
            state_d      = ST_IDLE;
            byte_valid_d = 1'b0;
            byte_data_d  = '0;
         end
      endcase

      // Last byte accepted: count it, then halt, chain the next command, or go idle
      if (done_s) begin
         cmd_count_d = cmd_count_q + 16'd1;
         if (stage_word_s[OPC_LSB +: OPCODE_WIDTH] == OPCODE_WIDTH'(OP_HALT)) begin
            state_d      = ST_HALTED;
            byte_valid_d = 1'b0;
            byte_data_d  = '0;
            halted_d     = 1'b1;
         end else if (!q_empty_s) begin
            pop_s        = 1'b1;
            stage_d      = q_dout_s;
            state_d      = ST_LO;
            byte_valid_d = 1'b1;
            byte_data_d  = next_word_s[FIFO_DATA_WIDTH-1:0];
         end else begin
            state_d      = ST_IDLE;
            byte_valid_d = 1'b0;
            byte_data_d  = '0;
         end
      end else begin
         cmd_count_d = cmd_count_q;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         stage_q       <= '0;
         byte_valid_q  <= 1'b0;
         byte_data_q   <= '0;
         cmd_count_q   <= 16'd0;
         halted_q      <= 1'b0;
         halt_acc_q    <= 1'b0;
         err_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         stage_q       <= stage_d;
         byte_valid_q  <= byte_valid_d;
         byte_data_q   <= byte_data_d;
         cmd_count_q   <= cmd_count_d;
         halted_q      <= halted_d;
         halt_acc_q    <= halt_acc_d;
         err_illegal_q <= err_illegal_d;
      end
   end

endmodule

// File: tb/tb_cmd_stream_encoder.sv
// Scoreboard bench for cmd_stream_encoder: directed commands push their
// hand-computed bytes into a queue; a monitor pops and compares on every
// byte handshake.
module tb_cmd_stream_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_opcode;
   logic [2:0] cmd_flags;
   logic [8:0] cmd_address;
   logic [8:0] cmd_store_addr;
   logic       byte_valid;
   logic       byte_ready;
   logic [7:0] byte_data;
   logic       busy;
   logic       halted;
   logic       err_illegal;
   logic [15:0] cmd_count;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q [$];
   logic [7:0] mon_exp;

   logic [7:0] ld_lo [7];
   logic [7:0] ld_hi [7];

   cmd_stream_encoder dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_opcode     (cmd_opcode),
      .cmd_flags      (cmd_flags),
      .cmd_address    (cmd_address),
      .cmd_store_addr (cmd_store_addr),
      .byte_valid     (byte_valid),
      .byte_ready     (byte_ready),
      .byte_data      (byte_data),
      .busy           (busy),
      .halted         (halted),
      .err_illegal    (err_illegal),
      .cmd_count      (cmd_count)
   );

   always #5 clk = ~clk;

   // Monitor: every byte handshake must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && byte_valid && byte_ready) begin
         total = total + 1;
         if (exp_q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL unexpected_byte got=%h expected=none", byte_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (byte_data !== mon_exp) begin
               bad = bad + 1;
               $display("FAIL byte_data got=%h expected=%h", byte_data, mon_exp);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [2:0] fl,
                       input logic [8:0] ad, input logic [8:0] sa);
      int n;
      n = 0;
      @(posedge clk); #1;
      cmd_valid      = 1'b1;
      cmd_opcode     = op;
      cmd_flags      = fl;
      cmd_address    = ad;
      cmd_store_addr = sa;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!cmd_ready) begin
         total = total + 1;
         bad   = bad + 1;
         $display("FAIL send_timeout got=cmd_ready0 expected=cmd_ready1");
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || byte_valid || exp_q.size() != 0) && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (busy || byte_valid || exp_q.size() != 0) begin
         total = total + 1;
         bad   = bad + 1;
         $display("FAIL drain_timeout got=busy%0d left=%0d expected=idle", busy, exp_q.size());
      end
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (!byte_valid && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("wait_valid", {31'd0, byte_valid}, 32'd1);
   endtask

   task automatic check_burst(input int len);
      for (int k = 0; k < len; k++) begin
         chk("no_bubble", {31'd0, byte_valid}, 32'd1);
         if (k < len - 1) @(negedge clk);
      end
   endtask

   initial begin
      int idx;
      ld_lo[0] = 8'h83; ld_hi[0] = 8'h00;
      ld_lo[1] = 8'h03; ld_hi[1] = 8'h01;
      ld_lo[2] = 8'h83; ld_hi[2] = 8'h01;
      ld_lo[3] = 8'h03; ld_hi[3] = 8'h02;
      ld_lo[4] = 8'h83; ld_hi[4] = 8'h02;
      ld_lo[5] = 8'h03; ld_hi[5] = 8'h03;
      ld_lo[6] = 8'h83; ld_hi[6] = 8'h03;

      rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 3'd0; cmd_flags = 3'd0;
      cmd_address = 9'd0; cmd_store_addr = 9'd0; byte_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd_ready",  {31'd0, cmd_ready},   32'd1);
      chk("rst_byte_valid", {31'd0, byte_valid},  32'd0);
      chk("rst_byte_data",  {24'd0, byte_data},   32'd0);
      chk("rst_busy",       {31'd0, busy},        32'd0);
      chk("rst_halted",     {31'd0, halted},      32'd0);
      chk("rst_err",        {31'd0, err_illegal}, 32'd0);
      chk("rst_count",      {16'd0, cmd_count},   32'd0);

      // FETCH flags=001 addr=0x0A5 -> 0x89 0x52, first byte two cycles after accept
      exp_q.push_back(8'h89); exp_q.push_back(8'h52);
      send(3'd1, 3'b001, 9'h0A5, 9'h000);
      @(negedge clk);
      chk("latency_c1", {31'd0, byte_valid}, 32'd0);
      @(negedge clk);
      chk("latency_c2", {31'd0, byte_valid}, 32'd1);
      wait_idle();
      chk("fetch_count", {16'd0, cmd_count}, 32'd1);

      // STORE with address word -> 0x10 0x00 0xFF 0x01 back-to-back
      exp_q.push_back(8'h10); exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
      send(3'd0, 3'b010, 9'h000, 9'h1FF);
      wait_valid();
      check_burst(4);
      wait_idle();
      chk("store_count", {16'd0, cmd_count}, 32'd2);

      // Illegal opcode 6: one-cycle error pulse, no bytes, count unchanged
      send(3'd6, 3'b000, 9'h000, 9'h000);
      @(negedge clk);
      chk("err_pulse", {31'd0, err_illegal}, 32'd1);
      @(negedge clk);
      chk("err_clear", {31'd0, err_illegal}, 32'd0);
      chk("err_busy",  {31'd0, busy},        32'd0);
      chk("err_count", {16'd0, cmd_count},   32'd2);

      // NOP with junk fields -> 0x05 0x00
      exp_q.push_back(8'h05); exp_q.push_back(8'h00);
      send(3'd5, 3'b111, 9'h155, 9'h000);
      wait_idle();
      chk("nop_count", {16'd0, cmd_count}, 32'd3);

      // Backpressure: offer 7 LOADs with byte_ready=0, only 5 fit
      @(posedge clk); #1;
      byte_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (idx < 7) begin
            cmd_valid   = 1'b1;
            cmd_opcode  = 3'd3;
            cmd_flags   = 3'b000;
            cmd_address = 9'(idx + 1);
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
         if (cmd_valid && cmd_ready) begin
            exp_q.push_back(ld_lo[idx]);
            exp_q.push_back(ld_hi[idx]);
            idx++;
         end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("bp_accepted",  idx,                        32'd5);
      chk("bp_cmd_ready", {31'd0, cmd_ready},         32'd0);
      chk("bp_valid",     {31'd0, byte_valid},        32'd1);
      chk("bp_data_hold", {24'd0, byte_data},         32'h83);
      @(posedge clk); #1;
      byte_ready = 1'b1;
      wait_idle();
      chk("bp_count", {16'd0, cmd_count}, 32'd8);

      // Reset after the first byte of a STORE-with-address, with a FETCH queued behind
      @(posedge clk); #1;
      byte_ready = 1'b0;
      exp_q.push_back(8'h10);
      send(3'd0, 3'b010, 9'h012, 9'h034);
      send(3'd1, 3'b000, 9'h005, 9'h000);
      wait_valid();
      @(posedge clk); #1;
      byte_ready = 1'b1;
      @(posedge clk); #1;
      byte_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, byte_valid}, 32'd0);
      chk("mid_rst_busy",  {31'd0, busy},       32'd0);
      chk("mid_rst_count", {16'd0, cmd_count},  32'd0);
      chk("mid_rst_ready", {31'd0, cmd_ready},  32'd1);
      byte_ready = 1'b1;
      exp_q.push_back(8'h01); exp_q.push_back(8'h00);
      send(3'd1, 3'b000, 9'h000, 9'h000);
      wait_idle();
      chk("post_rst_count", {16'd0, cmd_count}, 32'd1);

      // RUN then HALT queued under backpressure, then streamed with no bubble
      @(posedge clk); #1;
      byte_ready = 1'b0;
      exp_q.push_back(8'hBA); exp_q.push_back(8'h01);
      exp_q.push_back(8'h04); exp_q.push_back(8'h00);
      send(3'd2, 3'b111, 9'h003, 9'h000);
      send(3'd4, 3'b111, 9'h1FF, 9'h000);
      @(negedge clk);
      chk("halt_acc_ready", {31'd0, cmd_ready}, 32'd0);
      chk("pre_halted",     {31'd0, halted},    32'd0);
      @(posedge clk); #1;
      byte_ready = 1'b1;
      @(negedge clk);
      check_burst(4);
      wait_idle();
      chk("halted",         {31'd0, halted},     32'd1);
      chk("halt_ready",     {31'd0, cmd_ready},  32'd0);
      chk("halt_valid",     {31'd0, byte_valid}, 32'd0);
      chk("halt_count",     {16'd0, cmd_count},  32'd3);

      // Commands offered after HALT are ignored
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_opcode = 3'd1; cmd_flags = 3'b001; cmd_address = 9'h0A5;
      repeat (6) @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_halt_ready", {31'd0, cmd_ready},  32'd0);
      chk("post_halt_count", {16'd0, cmd_count},  32'd3);
      chk("post_halt_busy",  {31'd0, busy},       32'd0);
      chk("post_halt_hold",  {31'd0, halted},     32'd1);
      chk("scoreboard_empty", exp_q.size(),       32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
